// File: rtl/slice_mux.sv
// Encoder-side slice interleaver: takes whole chunks round-robin from the slice
// encoders and byte-packs them gap-free into a single 256-bit output stream.
module slice_mux #(
  parameter int MAX_NBR_SLICES  = 2,
  parameter int MAX_SLICE_WIDTH = 2560
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [9:0]                    slices_per_line,
  input  logic [15:0]                   chunk_size,
  input  logic [23:0]                   chunks_in_frame,
  input  logic                          in_sof,
  input  logic [256*MAX_NBR_SLICES-1:0] in_data_p,
  input  logic [MAX_NBR_SLICES-1:0]     in_valid,
  output logic [MAX_NBR_SLICES-1:0]     in_ready,
  output logic [255:0]                  out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_sof,
  output logic                          out_eof
);

  localparam int AW = (MAX_NBR_SLICES > 1) ? $clog2(MAX_NBR_SLICES) : 1;

  if (MAX_NBR_SLICES < 2 || MAX_SLICE_WIDTH < 1) begin : g_param_check
    $error("slice_mux: illegal parameter values");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [511:0]    acc_q, acc_d;
  logic [6:0]      fill_q, fill_d;
  logic [11:0]     word_cnt_q, word_cnt_d;
  logic [23:0]     chunk_cnt_q, chunk_cnt_d;
  logic [AW-1:0]   active_q, active_d;
  logic            sof_pend_q, sof_pend_d;

  logic [11:0]     wpc;
  logic [4:0]      rem;
  logic            pop, room, accept, last_word, last_chunk;
  logic [6:0]      base;
  logic [5:0]      n_bytes;
  logic [255:0]    in_word, word_m;
  logic [511:0]    placed, acc_shift;
  logic [9:0]      act_inc;

  assign rem        = chunk_size[4:0];
  assign wpc        = {1'b0, chunk_size[15:5]} + {11'd0, |rem};
  assign last_word  = (word_cnt_q == wpc - 12'd1);
  assign last_chunk = (chunk_cnt_q == chunks_in_frame - 24'd1);
  assign n_bytes    = (last_word && rem != 5'd0) ? {1'b0, rem} : 6'd32;

  assign out_valid = (fill_q >= 7'd32) | (state_q == S_DRAIN && fill_q != 7'd0);
  assign out_data  = acc_q[255:0];
  assign out_sof   = out_valid & sof_pend_q;
  assign out_eof   = (state_q == S_DRAIN) && fill_q != 7'd0 && fill_q <= 7'd32;

  assign pop  = out_valid & out_ready;
  // Byte position where an accepted word lands, after this cycle's pop
  assign base = fill_q - (pop ? 7'd32 : 7'd0);
  assign room = (state_q == S_RUN) && (base < 7'd32);

  always_comb begin
    in_ready           = '0;
    in_ready[active_q] = room;
  end

  assign in_word = in_data_p[{active_q, 8'h00} +: 256];
  assign accept  = room & in_valid[active_q] & ~flush & ~in_sof;

  always_comb begin
    word_m = '0;
    for (int b = 0; b < 32; b++) begin
      if (6'(b) < n_bytes) word_m[8*b +: 8] = in_word[8*b +: 8];
    end
  end

  assign placed    = {256'd0, word_m} << {base[4:0], 3'b000};
  assign acc_shift = pop ? {256'd0, acc_q[511:256]} : acc_q;
  assign act_inc   = 10'(active_q) + 10'd1;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_shift;
    fill_d      = base;
    word_cnt_d  = word_cnt_q;
    chunk_cnt_d = chunk_cnt_q;
    active_d    = active_q;
    sof_pend_d  = sof_pend_q & ~pop;
    case (state_q)
      S_RUN: begin
        if (accept) begin
          acc_d  = acc_shift | placed;
          fill_d = base + {1'b0, n_bytes};
          if (last_word) begin
            word_cnt_d  = '0;
            chunk_cnt_d = chunk_cnt_q + 24'd1;
            active_d    = (act_inc >= slices_per_line || act_inc >= 10'(MAX_NBR_SLICES))
                          ? '0 : AW'(act_inc);
            if (last_chunk) state_d = S_DRAIN;
          end else begin
            word_cnt_d = word_cnt_q + 12'd1;
          end
        end
      end
      S_DRAIN: begin
        if (fill_q == 7'd0 || (pop && fill_q <= 7'd32)) begin
          state_d = S_IDLE;
          fill_d  = '0;
          acc_d   = '0;
        end
      end
      default: ;
    endcase
    // flush wins over in_sof; in_sof mid-frame is an abort plus a fresh start
    if (flush || in_sof) begin
      state_d     = flush ? S_IDLE : S_RUN;
      acc_d       = '0;
      fill_d      = '0;
      word_cnt_d  = '0;
      chunk_cnt_d = '0;
      active_d    = '0;
      sof_pend_d  = ~flush;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      fill_q      <= '0;
      word_cnt_q  <= '0;
      chunk_cnt_q <= '0;
      active_q    <= '0;
      sof_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      word_cnt_q  <= word_cnt_d;
      chunk_cnt_q <= chunk_cnt_d;
      active_q    <= active_d;
      sof_pend_q  <= sof_pend_d;
    end
  end

endmodule
